// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag controller of a dual-clock FIFO.
// Synchronizes the Gray write pointer into rd_clk and derives the read address, flags and occupancy.
module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH    = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic [ADDR_WIDTH:0]   wq_wptr_gray,
   input  logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ADDR_WIDTH:0]   rd_ptr_gray,
   output logic                  rd_empty,
   output logic                  rd_almost_empty,
   output logic [ADDR_WIDTH:0]   rd_count,
   output logic                  rd_underflow
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

   logic [PW-1:0] sync_q [SYNC_STAGES];
   logic [PW-1:0] wsync_gray;
   logic [PW-1:0] wsync_bin;
   logic [PW-1:0] rd_ptr_bin;
   logic [PW-1:0] rd_ptr_bin_nxt;
   logic [PW-1:0] rd_ptr_gray_nxt;
   logic [PW-1:0] rd_count_nxt;
   logic          rd_fire;

   // Only the Gray form of the write pointer crosses into this domain.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= wq_wptr_gray;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign wsync_gray = sync_q[SYNC_STAGES-1];

   // Bit i of the binary value is the XOR of all Gray bits at and above i.
   always_comb begin
      wsync_bin = '0;
      for (int unsigned i = 0; i < PW; i++) wsync_bin[i] = ^(wsync_gray >> i);
   end

   always_comb begin
      rd_fire         = rd_en & ~rd_empty;
      rd_ptr_bin_nxt  = rd_ptr_bin + PW'(rd_fire);
      rd_ptr_gray_nxt = rd_ptr_bin_nxt ^ (rd_ptr_bin_nxt >> 1);
      rd_count_nxt    = wsync_bin - rd_ptr_bin_nxt;
   end

   // Flags are computed from next-state pointers so a read of the last word
   // raises rd_empty on the very next edge and a second read is refused.
   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         rd_ptr_bin      <= '0;
         rd_ptr_gray     <= '0;
         rd_empty        <= 1'b1;
         rd_almost_empty <= 1'b1;
         rd_count        <= '0;
         rd_underflow    <= 1'b0;
      end else begin
         rd_ptr_bin      <= rd_ptr_bin_nxt;
         rd_ptr_gray     <= rd_ptr_gray_nxt;
         rd_empty        <= (rd_ptr_gray_nxt == wsync_gray);
         rd_almost_empty <= (rd_count_nxt <= AE_TH);
         rd_count        <= rd_count_nxt;
         rd_underflow    <= rd_en & rd_empty;
      end
   end

   assign rd_addr = rd_ptr_bin[ADDR_WIDTH-1:0];

endmodule
